// File: rtl/byte_serial_adder_if.sv
// Handshake bundle for byte_serial_adder: input beat stream, result byte stream, status.
// master: the side that feeds operand bytes and consumes result bytes.
// slave: the adder itself. BYTE_SERIAL_ADDER_OVF_EN adds the ovf signal.
interface byte_serial_adder_if;
  logic       cin;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a_byte;
  logic [7:0] b_byte;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_byte;
  logic       out_last;
  logic       cout;
  logic       busy;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  modport master (
    output cin, in_valid, a_byte, b_byte, out_ready,
    input  in_ready, out_valid, sum_byte, out_last, cout, busy
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  cin, in_valid, a_byte, b_byte, out_ready,
    output in_ready, out_valid, sum_byte, out_last, cout, busy
`ifdef BYTE_SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/byte_serial_adder.sv
// Byte-serial NBYTES-byte adder, LSB byte first, carry chained between beats in carry_q.
// Latency: one cycle from accepted beat to out_valid; one beat per cycle with out_ready high.
// Backpressure: in_ready = !out_valid | out_ready; output registers hold while out_ready is low.
// Optional BYTE_SERIAL_ADDER_OVF_EN adds a signed-overflow flag registered with the last byte.

// 8-bit adder with carry in/out; one beat of the word.
module adder_8_s (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4  // legal range 2..16
) (
  input logic                clk,
  input logic                rst,
  byte_serial_adder_if.slave bus
);
  localparam int            CW        = $clog2(NBYTES);
  localparam logic [CW-1:0] LAST_BEAT = CW'(NBYTES - 1);

  logic [CW-1:0] beat_cnt;
  logic          carry_q;
  logic          accept;
  logic          is_last;
  logic          add_cin;
  logic [7:0]    add_s;
  logic          add_cout;

  logic          out_valid_q;
  logic [7:0]    sum_byte_q;
  logic          out_last_q;
  logic          cout_q;

  // The output stage can take a new beat when empty or when it is being drained this cycle.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign is_last      = (beat_cnt == LAST_BEAT);
  // The port carry only enters on the first beat; later beats use the chained carry.
  assign add_cin      = (beat_cnt == '0) ? bus.cin : carry_q;
  assign bus.busy     = (beat_cnt != '0);

  adder_8_s u_add (
    .a    (bus.a_byte),
    .b    (bus.b_byte),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // Beat position and inter-beat carry advance only on an accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      carry_q  <= add_cout;
      beat_cnt <= is_last ? '0 : beat_cnt + CW'(1);
    end
  end

  // One-deep output register: load on accept, retire on out_ready, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sum_byte_q  <= 8'd0;
      out_last_q  <= 1'b0;
      cout_q      <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      sum_byte_q  <= add_s;
      out_last_q  <= is_last;
      cout_q      <= is_last ? add_cout : 1'b0;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.sum_byte  = sum_byte_q;
  assign bus.out_last  = out_last_q;
  assign bus.cout      = cout_q;

`ifdef BYTE_SERIAL_ADDER_OVF_EN
  logic msb_carry_in;
  logic ovf_q;

  // Carry into bit 7 is recovered from the sum bit: s7 = a7 ^ b7 ^ c7.
  assign msb_carry_in = add_s[7] ^ bus.a_byte[7] ^ bus.b_byte[7];

  // Overflow is only defined for the MSB byte; it rides along with that byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= is_last ? (msb_carry_in ^ add_cout) : 1'b0;
    end
  end

  assign bus.ovf = ovf_q;
`endif
endmodule
